countdown_sched: RTL and testbench
==================================

Name: countdown_sched

Overview:
- Round-robin scheduler that shares one WIDTH-bit down-counter timer among NREQ requesters.
- Arbitrates the requests and loads the winner's start value.
- Decrements the counter on each enabled clock edge, then returns a one-cycle done pulse to the winner.
- Sits between requester logic and the shared countdown datapath; the counter lives inside this block.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 3, counter width in bits
IDXW, 2, winner-index width; must equal clog2(NREQ)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (reset==0 resets the block)
en  input  1  count-enable tick; the counter decrements only on edges with en==1
req  input  NREQ  per-requester request level
load_val  input  NREQ*WIDTH  start values; requester i uses bits [i*WIDTH +: WIDTH]
gnt  output  NREQ  one-hot grant, registered
done  output  NREQ  one-cycle completion pulse to the granted requester, registered
busy  output  1  high while a grant is active
count  output  WIDTH  current counter value, registered
owner  output  IDXW  index of the current or last winner

Behaviour:
- Reset asserted (reset==0), immediate, independent of clk:
  - state=IDLE, gnt=0, done=0, busy=0, owner=0.
  - count = all ones (3'b111 at default).
  - rr pointer ptr=0.
- States: IDLE, COUNT, DONE. All outputs are registered. No combinational path from input to output.
- IDLE:
  - If req==0: hold. count keeps its last value.
  - Else choose winner w = first set req bit, searching from ptr upward and wrapping modulo NREQ.
  - Next edge: gnt=onehot(w), owner=w, count=load_val[w], busy=1, state=COUNT.
  - Latency: req high -> gnt high is 1 clock. en is ignored in IDLE.
- COUNT:
  - en==0: count holds.
  - en==1 and count>0: count=count-1.
  - en==1 and count==0: done[w]=1 and state=DONE. count stays 0 and gnt stays high.
  - A load value of 0 finishes on the first enabled edge.
  - A load value of V gives V+1 enabled edges from the COUNT entry to done.
- DONE (exactly one cycle, independent of en and req):
  - Next edge: done=0, gnt=0, busy=0, ptr=(w+1) mod NREQ, state=IDLE.
  - count holds 0 until the next load.
- Re-arbitration:
  - The earliest new grant comes 1 clock after DONE, so there is a minimum of one idle cycle between grants.
  - A requester that holds req continuously after its own done has the lowest priority in the next arbitration.
- Requests arriving in COUNT or DONE are only sampled in IDLE. The block never drops or queues them.
- req[w] deasserted during COUNT:
  - Without ABORT_EN: ignored, and the countdown completes normally.
  - With ABORT_EN: see Optional Feature.
- load_val is sampled only on the grant edge. Changes during COUNT have no effect.
- Reset asserted mid-COUNT: immediate return to the reset values. No done pulse is issued.
- Invariants:
  - gnt is zero or one-hot.
  - done is never set without the matching gnt bit.
  - busy == |gnt.

Optional Feature:
- Macro: COUNTDOWN_SCHED_ABORT_EN.
- Defined:
  - In COUNT, an edge with req[owner]==0 aborts: gnt=0, busy=0, done stays 0, ptr=(owner+1) mod NREQ, state=IDLE.
  - count holds its current value.
  - Abort has priority over count==0 completion on the same edge.
- Not defined: no abort path. req is not examined after the grant.

Test Plan:
1. Reset: hold reset=0, toggle clk -> count=3'b111, gnt=0, busy=0, done=0. Release reset, no req -> all outputs unchanged.
2. Single request:
   - Stimulus: req=4'b0010, load_val[1]=3, en=1 continuously.
   - Expected: gnt=4'b0010 one clock later; count sequence 3,2,1,0.
   - Then: done=4'b0010 for exactly one cycle; gnt/busy drop the following edge.
3. Enable gating: same as scenario 2 but en toggling 1,0,1,0... -> count decrements only on en=1 edges; done comes after 4 enabled edges.
4. Round-robin fairness:
   - Stimulus: req=4'b1111 held, load_val all 0, en=1.
   - Expected: grant order 0,1,2,3,0. Each grant lasts 2 cycles (COUNT, DONE), followed by 1 idle cycle.
5. Zero load and priority:
   - Stimulus: req=4'b0101, ptr=2.
   - Expected: requester 2 is granted first, then 0. load_val=0 gives done one enabled edge after grant.
6. Mid-operation events:
   - Reset during COUNT with count=2 -> outputs return to reset values immediately, no done.
   - With COUNTDOWN_SCHED_ABORT_EN: drop req[owner] with count=2 -> gnt=0 next edge, done never pulses, count holds 2.

Source files
------------

// File: rtl/countdown_sched.sv
// countdown_sched: round-robin scheduler that shares one down-counter timer
// among NREQ requesters. The winner of an arbitration gets its start value
// loaded into the counter. The counter decrements on enabled edges, and the
// winner gets a one-cycle done pulse when the counter expires.
//
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous, active-low reset
//   en       - count-enable tick, honoured only while counting
//   req      - per-requester request level
//   load_val - packed start values, requester i at [i*WIDTH +: WIDTH]
//   gnt      - registered one-hot grant
//   done     - registered one-cycle completion pulse to the granted requester
//   busy     - high while a grant is active
//   count    - registered counter value
//   owner    - index of the current or most recent winner
//
// Optional feature: define COUNTDOWN_SCHED_ABORT_EN to let the owner cancel
// its countdown by dropping its request. Abort wins over completion on the
// same edge. Without the macro, req is not looked at after the grant.

module countdown_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 3,
  parameter int IDXW  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] load_val,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic [WIDTH-1:0]      count,
  output logic [IDXW-1:0]       owner
);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t           state;
  logic [IDXW-1:0]  ptr;
  logic [NREQ-1:0]  req_rot;
  logic [IDXW-1:0]  offset;
  logic [IDXW:0]    win_sum;
  logic [IDXW-1:0]  win_idx;
  logic [IDXW-1:0]  owner_next;
  logic [WIDTH-1:0] lv [NREQ];

  // Unpack the start values so the winner's value can be picked by index.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      lv[i] = load_val[i*WIDTH +: WIDTH];
    end
  end

  // Rotate the requests so that bit 0 is the requester at ptr. The lowest
  // set bit is then the distance from ptr to the winner. The winner index is
  // ptr plus that distance, wrapped modulo NREQ. NREQ need not be a power of
  // two, so the wrap is an explicit subtract.
  always_comb begin
    req_rot = NREQ'({req, req} >> ptr);
    offset  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_rot[k]) offset = IDXW'(k);
    end
    win_sum = {1'b0, ptr} + {1'b0, offset};
    if (win_sum >= (IDXW+1)'(NREQ)) win_sum = win_sum - (IDXW+1)'(NREQ);
    win_idx = win_sum[IDXW-1:0];
  end

  // The pointer moves to just past the finishing owner. A requester that
  // keeps its request asserted therefore ranks last in the next round.
  always_comb begin
    owner_next = (owner == IDXW'(NREQ - 1)) ? '0 : owner + IDXW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      gnt   <= '0;
      done  <= '0;
      busy  <= 1'b0;
      owner <= '0;
      count <= '1;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            gnt   <= NREQ'(1) << win_idx;
            owner <= win_idx;
            count <= lv[win_idx];
            busy  <= 1'b1;
            state <= COUNT;
          end
        end
        COUNT: begin
`ifdef COUNTDOWN_SCHED_ABORT_EN
          if (!req[owner]) begin
            gnt   <= '0;
            busy  <= 1'b0;
            ptr   <= owner_next;
            state <= IDLE;
          end else
`endif
          if (en) begin
            // At zero the counter holds, and gnt (already one-hot on the
            // owner) doubles as the done pulse.
            if (count == '0) begin
              done  <= gnt;
              state <= DONE;
            end else begin
              count <= count - 1'b1;
            end
          end
        end
        DONE: begin
          done  <= '0;
          gnt   <= '0;
          busy  <= 1'b0;
          ptr   <= owner_next;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_sched.sv
// tb_countdown_sched: self-checking bench for countdown_sched. A behavioural
// model tracks the grant holder and the number of enabled edges still owed
// before done. Each scenario task compares the DUT outputs with the model and
// with hand-derived constants. Build with +define+COUNTDOWN_SCHED_ABORT_EN to
// exercise the abort path.

module tb_countdown_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 3;
  localparam int IDXW  = 2;
  localparam int VW    = 2*NREQ + 1 + WIDTH + IDXW;

  logic                  clk;
  logic                  reset;
  logic                  en;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] load_val;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic [WIDTH-1:0]      count;
  logic [IDXW-1:0]       owner;

  int checks;
  int errors;

  countdown_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .IDXW(IDXW)) dut (
    .clk(clk), .reset(reset), .en(en), .req(req), .load_val(load_val),
    .gnt(gnt), .done(done), .busy(busy), .count(count), .owner(owner)
  );

  always #5 clk = ~clk;

  // Model state: mHeld means a grant is outstanding, mFinishing means the
  // done cycle is being presented, and mLeft is the number of enabled edges
  // still needed before done fires.
  bit mHeld;
  bit mFinishing;
  int mOwner;
  int mPtr;
  int mLeft;
  int mCount;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mHeld = 0; mFinishing = 0; mOwner = 0; mPtr = 0; mLeft = 0;
      mCount = (1 << WIDTH) - 1;
    end else if (mFinishing) begin
      mHeld = 0; mFinishing = 0;
      mPtr = (mOwner + 1) % NREQ;
    end else if (mHeld) begin
`ifdef COUNTDOWN_SCHED_ABORT_EN
      if (!req[mOwner]) begin
        mHeld = 0;
        mPtr = (mOwner + 1) % NREQ;
      end else
`endif
      if (en) begin
        mLeft--;
        if (mLeft == 0) mFinishing = 1;
        else mCount = mLeft - 1;
      end
    end else if (req != '0) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        logic [WIDTH-1:0] v;
        idx = (mPtr + k) % NREQ;
        if (!mHeld && req[idx]) begin
          v = load_val[idx*WIDTH +: WIDTH];
          mHeld = 1; mOwner = idx;
          mCount = int'(v); mLeft = int'(v) + 1;
        end
      end
    end
  end

  function automatic logic [VW-1:0] modelOut();
    logic [NREQ-1:0] g;
    logic [NREQ-1:0] d;
    g = mHeld ? (NREQ'(1) << mOwner) : '0;
    d = mFinishing ? g : '0;
    return {g, d, mHeld, WIDTH'(mCount), IDXW'(mOwner)};
  endfunction

  function automatic logic [VW-1:0] dutOut();
    return {gnt, done, busy, count, owner};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic resetPulse();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic setLoad(input int idx, input int val);
    load_val[idx*WIDTH +: WIDTH] = WIDTH'(val);
  endtask

  task automatic test_reset();
    logic [VW-1:0] rstVec;
    rstVec = {{NREQ{1'b0}}, {NREQ{1'b0}}, 1'b0, {WIDTH{1'b1}}, {IDXW{1'b0}}};
    reset = 1'b0;
    repeat (3) tick();
    checks++;
    if (dutOut() !== rstVec) begin
      errors++;
      $display("[TB] FAIL reset_hold: got %b expected %b", dutOut(), rstVec);
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dutOut() !== rstVec) begin
        errors++;
        $display("[TB] FAIL reset_idle cycle %0d: got %b expected %b", i, dutOut(), rstVec);
      end
    end
  endtask

  task automatic test_single();
    int donePulses;
    donePulses = 0;
    load_val = NREQ*WIDTH'($urandom);
    setLoad(1, 3);
    req = 4'b0010;
    en = 1'b1;
    tick();
    req = '0;
    checks++;
    if (gnt !== 4'b0010 || count !== 3'd3) begin
      errors++;
      $display("[TB] FAIL single_grant: got gnt=%b count=%0d expected gnt=0010 count=3", gnt, count);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done == 4'b0010) donePulses++;
      checks++;
      if (dutOut() !== modelOut()) begin
        errors++;
        $display("[TB] FAIL single_seq cycle %0d: got %b expected %b", i, dutOut(), modelOut());
      end
    end
    checks++;
    if (donePulses != 1) begin
      errors++;
      $display("[TB] FAIL single_done_pulses: got %0d expected 1", donePulses);
    end
  endtask

  task automatic test_en_gating();
    int enEdges;
    int edgesAtDone;
    enEdges = 0;
    edgesAtDone = -1;
    setLoad(1, 3);
    req = 4'b0010;
    en = 1'b0;
    tick();
    req = '0;
    for (int i = 0; i < 12; i++) begin
      en = (i % 2 == 0);
      tick();
      if (en) enEdges++;
      if (done != '0 && edgesAtDone < 0) edgesAtDone = enEdges;
      checks++;
      if (dutOut() !== modelOut()) begin
        errors++;
        $display("[TB] FAIL en_gating cycle %0d: got %b expected %b", i, dutOut(), modelOut());
      end
    end
    checks++;
    if (edgesAtDone != 4) begin
      errors++;
      $display("[TB] FAIL en_gating_edges: got %0d expected 4", edgesAtDone);
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int expOrder[5] = '{0, 1, 2, 3, 0};
    logic [NREQ-1:0] prevGnt;
    en = 1'b1;
    req = '0;
    load_val = '0;
    resetPulse();
    prevGnt = '0;
    req = 4'b1111;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (gnt != '0 && prevGnt == '0) begin
        for (int b = 0; b < NREQ; b++) if (gnt[b]) order.push_back(b);
      end
      prevGnt = gnt;
      checks++;
      if (dutOut() !== modelOut()) begin
        errors++;
        $display("[TB] FAIL rr_seq cycle %0d: got %b expected %b", i, dutOut(), modelOut());
      end
    end
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (j >= order.size() || order[j] != expOrder[j]) begin
        errors++;
        $display("[TB] FAIL rr_order slot %0d: got %0d expected %0d", j,
                 (j < order.size()) ? order[j] : -1, expOrder[j]);
      end
    end
    req = '0;
  endtask

  task automatic test_zero_priority();
    en = 1'b1;
    load_val = '0;
    resetPulse();
    req = 4'b0010;
    tick();
    req = '0;
    tick();
    tick();
    req = 4'b0101;
    tick();
    checks++;
    if (gnt !== 4'b0100 || owner !== 2'd2) begin
      errors++;
      $display("[TB] FAIL prio_first: got gnt=%b owner=%0d expected gnt=0100 owner=2", gnt, owner);
    end
    tick();
    checks++;
    if (done !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL zero_load_done: got %b expected 0100", done);
    end
    tick();
    tick();
    checks++;
    if (gnt !== 4'b0001 || dutOut() !== modelOut()) begin
      errors++;
      $display("[TB] FAIL prio_second: got %b expected %b", dutOut(), modelOut());
    end
    req = '0;
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    logic [VW-1:0] rstVec;
    rstVec = {{NREQ{1'b0}}, {NREQ{1'b0}}, 1'b0, {WIDTH{1'b1}}, {IDXW{1'b0}}};
    en = 1'b1;
    setLoad(3, 5);
    req = 4'b1000;
    tick();
    req = '0;
    repeat (3) tick();
    checks++;
    if (count !== 3'd2 || gnt !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL mid_setup: got count=%0d gnt=%b expected count=2 gnt=1000", count, gnt);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (dutOut() !== rstVec) begin
      errors++;
      $display("[TB] FAIL mid_reset_async: got %b expected %b", dutOut(), rstVec);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (done !== '0 || dutOut() !== rstVec) begin
        errors++;
        $display("[TB] FAIL mid_reset_hold cycle %0d: got %b expected %b", i, dutOut(), rstVec);
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_req_drop();
    logic [VW-1:0] expVec;
    int donePulses;
    donePulses = 0;
    en = 1'b1;
    setLoad(3, 5);
    req = 4'b1000;
    repeat (4) tick();
    req = '0;
    tick();
`ifdef COUNTDOWN_SCHED_ABORT_EN
    expVec = {4'b0000, 4'b0000, 1'b0, 3'd2, 2'd3};
`else
    expVec = {4'b1000, 4'b0000, 1'b1, 3'd1, 2'd3};
`endif
    checks++;
    if (dutOut() !== expVec) begin
      errors++;
      $display("[TB] FAIL req_drop: got %b expected %b", dutOut(), expVec);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done != '0) donePulses++;
    end
    checks++;
`ifdef COUNTDOWN_SCHED_ABORT_EN
    if (donePulses != 0 || count !== 3'd2) begin
`else
    if (donePulses != 1 || count !== 3'd0) begin
`endif
      errors++;
      $display("[TB] FAIL req_drop_tail: got pulses=%0d count=%0d", donePulses, count);
    end
  endtask

  task automatic test_random();
    resetPulse();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req = NREQ'($urandom);
      en = ($urandom_range(0, 3) != 0);
      load_val = (NREQ*WIDTH)'($urandom);
      tick();
      checks++;
      if (dutOut() !== modelOut()) begin
        errors++;
        $display("[TB] FAIL random cycle %0d: got %b expected %b", i, dutOut(), modelOut());
      end
      checks++;
      if (busy !== (gnt != '0) || (gnt & (gnt - 1'b1)) != '0 || (done & ~gnt) != '0) begin
        errors++;
        $display("[TB] FAIL random_invariant cycle %0d: got gnt=%b done=%b busy=%b", i, gnt, done, busy);
      end
    end
    req = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clk = 1'b0;
    reset = 1'b1;
    en = 1'b0;
    req = '0;
    load_val = '0;
    #2;
    test_reset();
    test_single();
    test_en_gating();
    test_round_robin();
    test_zero_priority();
    test_reset_mid();
    test_req_drop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
